// File: rtl/partial_reg_or_bank.sv
// Channel register bank with lifted MSBs feeding a registered bitwise OR, behind a 2-stage valid/ready pipeline.
// Optional: define PARTIAL_XFER_COUNT_EN to add a saturating 16-bit output-handshake counter (xfer_count).
module partial_reg_or_bank #(
    parameter int unsigned      NCH   = 2,
    parameter int unsigned      WIDTH = 2,
    parameter int unsigned      LIFT  = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESETN,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NCH*WIDTH-1:0]       I,
    input  logic [NCH-1:0]             ce,
    input  logic [NCH*LIFT-1:0]        lifted_input,
    output logic [WIDTH-1:0]           O,
    output logic                       O_valid,
    input  logic                       O_ready,
    output logic [(NCH+1)*LIFT-1:0]    lifted_output
`ifdef PARTIAL_XFER_COUNT_EN
    ,
    output logic [15:0]                xfer_count
`endif
);

    logic [WIDTH-1:0] ch_reg [NCH];
    logic             v1;
    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] or_word;
    logic [LIFT-1:0]  msb_or;

    assign transfer = v1 & (~O_valid | O_ready);
    assign in_ready = ~v1 | transfer;
    assign accept   = in_valid & in_ready;

    // Lifted MSB positions of each word come from outside; only the low bits come from the registers.
    always_comb begin
        or_word = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            or_word = or_word | {lifted_input[c*LIFT +: LIFT], ch_reg[c][WIDTH-LIFT-1:0]};
        end
    end

    always_comb begin
        lifted_output = '0;
        msb_or        = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            lifted_output[c*LIFT +: LIFT] = ch_reg[c][WIDTH-1 -: LIFT];
            msb_or = msb_or | ch_reg[c][WIDTH-1 -: LIFT];
        end
        lifted_output[NCH*LIFT +: LIFT] = msb_or;
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                ch_reg[c] <= INIT;
            end
            v1 <= 1'b0;
        end else if (accept) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (ce[c]) begin
                    ch_reg[c] <= I[c*WIDTH +: WIDTH];
                end
            end
            v1 <= 1'b1;
        end else if (transfer) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            O       <= '0;
            O_valid <= 1'b0;
        end else if (transfer) begin
            O       <= or_word;
            O_valid <= 1'b1;
        end else if (O_valid && O_ready) begin
            O_valid <= 1'b0;
        end
    end

`ifdef PARTIAL_XFER_COUNT_EN
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            xfer_count <= '0;
        end else if (O_valid && O_ready && (xfer_count != '1)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_partial_reg_or_bank.sv
// Directed bench for partial_reg_or_bank (NCH=2, WIDTH=2, LIFT=1, INIT=0): vector table plus
// back-pressure, streaming, reset and (with PARTIAL_XFER_COUNT_EN) counter sequences.
module tb_partial_reg_or_bank;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] I;
    logic [1:0] ce;
    logic [1:0] lifted_input;
    logic [1:0] O;
    logic       O_valid;
    logic       O_ready;
    logic [2:0] lifted_output;
`ifdef PARTIAL_XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [1:0] got [$];
    logic [1:0] expq [$];

    typedef struct {
        logic       iv;
        logic [3:0] i;
        logic [1:0] ce;
        logic [1:0] li;
        logic       ord;
        logic [1:0] e_o;
        logic       e_ov;
        logic       e_rdy;
        logic [2:0] e_lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    partial_reg_or_bank #(
        .NCH   (2),
        .WIDTH (2),
        .LIFT  (1),
        .INIT  (2'b00)
    ) dut (
        .CLK           (CLK),
        .ASYNCRESETN   (ASYNCRESETN),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .I             (I),
        .ce            (ce),
        .lifted_input  (lifted_input),
        .O             (O),
        .O_valid       (O_valid),
        .O_ready       (O_ready),
        .lifted_output (lifted_output)
`ifdef PARTIAL_XFER_COUNT_EN
        ,
        .xfer_count    (xfer_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Output handshakes are recorded at the falling edge, ahead of the rising edge that completes them.
    always @(negedge CLK) begin
        if (ASYNCRESETN && O_valid && O_ready) got.push_back(O);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [3:0] i, input logic [1:0] c,
                         input logic [1:0] li, input logic ord);
        in_valid     = iv;
        I            = i;
        ce           = c;
        lifted_input = li;
        O_ready      = ord;
    endtask

`ifdef PARTIAL_XFER_COUNT_EN
    task automatic stream(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 4'b0001, 2'b11, 2'b00, 1'b1);
            tick();
        end
        drive(1'b0, 4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        #3 ASYNCRESETN = 1'b0;
        tick();
        #2 ASYNCRESETN = 1'b1;
        tick();
    endtask
`endif

    initial begin
        vecs[0]  = '{1'b1, 4'b1001, 2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 3'b110};
        vecs[1]  = '{1'b0, 4'b0000, 2'b00, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 3'b110};
        vecs[2]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 3'b110};
        vecs[3]  = '{1'b1, 4'b0101, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 3'b000};
        vecs[4]  = '{1'b1, 4'b0010, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 3'b101};
        vecs[5]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 3'b101};
        vecs[6]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 3'b101};
        vecs[7]  = '{1'b1, 4'b1111, 2'b00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1, 3'b101};
        vecs[8]  = '{1'b0, 4'b0000, 2'b00, 2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 3'b101};
        vecs[9]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b11, 1'b1, 1'b1, 3'b101};
        vecs[10] = '{1'b0, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 3'b101};

        ASYNCRESETN = 1'b1;
        drive(1'b0, 4'b0000, 2'b00, 2'b00, 1'b0);
        repeat (2) @(posedge CLK);
        #3 ASYNCRESETN = 1'b0;
        #1;
        chk("rst O", 32'(O), 32'd0);
        chk("rst O_valid", 32'(O_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst lifted_output", 32'(lifted_output), 32'd0);
        repeat (2) @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].iv, vecs[k].i, vecs[k].ce, vecs[k].li, vecs[k].ord);
            tick();
            chk($sformatf("v%0d O", k), 32'(O), 32'(vecs[k].e_o));
            chk($sformatf("v%0d O_valid", k), 32'(O_valid), 32'(vecs[k].e_ov));
            chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].e_rdy));
            chk($sformatf("v%0d lifted_output", k), 32'(lifted_output), 32'(vecs[k].e_lo));
        end

        // Back-pressure: two beats enter, the third waits until O_ready returns.
        got.delete();
        drive(1'b1, 4'b0001, 2'b11, 2'b00, 1'b0);
        tick();
        chk("bp0 in_ready", 32'(in_ready), 32'd1);
        chk("bp0 lifted_output", 32'(lifted_output), 32'b000);
        chk("bp0 O_valid", 32'(O_valid), 32'd0);
        drive(1'b1, 4'b1000, 2'b11, 2'b00, 1'b0);
        tick();
        chk("bp1 O_valid", 32'(O_valid), 32'd1);
        chk("bp1 O", 32'(O), 32'b01);
        chk("bp1 in_ready", 32'(in_ready), 32'd0);
        chk("bp1 lifted_output", 32'(lifted_output), 32'b110);
        drive(1'b1, 4'b0110, 2'b11, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d O", k), 32'(O), 32'b01);
            chk($sformatf("stall%0d O_valid", k), 32'(O_valid), 32'd1);
            chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d lifted_output", k), 32'(lifted_output), 32'b110);
        end
        O_ready = 1'b1;
        #1 chk("release in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("release O", 32'(O), 32'b00);
        chk("release lifted_output", 32'(lifted_output), 32'b101);
        in_valid = 1'b0;
        tick();
        chk("bp last O", 32'(O), 32'b01);
        chk("bp last O_valid", 32'(O_valid), 32'd1);
        tick();
        chk("bp drained O_valid", 32'(O_valid), 32'd0);
        chk("bp count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp beat0", 32'(got[0]), 32'b01);
            chk("bp beat1", 32'(got[1]), 32'b00);
            chk("bp beat2", 32'(got[2]), 32'b01);
        end

        // Full-rate streaming with a small reference model of the OR.
        got.delete();
        expq.delete();
        for (int k = 0; k < 10; k++) begin
            logic [3:0] d;
            d = 4'((k * 5 + 3) & 15);
            expq.push_back({1'b0, d[2] | d[0]});
            drive(1'b1, d, 2'b11, 2'b00, 1'b1);
            #1 chk($sformatf("stream%0d in_ready", k), 32'(in_ready), 32'd1);
            tick();
            if (k >= 1) chk($sformatf("stream%0d O_valid", k), 32'(O_valid), 32'd1);
        end
        drive(1'b0, 4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (3) tick();
        chk("stream count", 32'(got.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < got.size()) chk($sformatf("stream beat%0d", k), 32'(got[k]), 32'(expq[k]));
        end

        // Reset while a result is held and stage 1 is loaded.
        drive(1'b1, 4'b1010, 2'b11, 2'b00, 1'b0);
        tick();
        drive(1'b1, 4'b1010, 2'b11, 2'b00, 1'b0);
        tick();
        chk("pre-rst O_valid", 32'(O_valid), 32'd1);
        chk("pre-rst lifted_output", 32'(lifted_output), 32'b111);
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("mid rst O", 32'(O), 32'd0);
        chk("mid rst O_valid", 32'(O_valid), 32'd0);
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        chk("mid rst lifted_output", 32'(lifted_output), 32'd0);
        drive(1'b0, 4'b0000, 2'b00, 2'b00, 1'b0);
        tick();
        #2 ASYNCRESETN = 1'b1;
        tick();
        chk("post rst O_valid", 32'(O_valid), 32'd0);

`ifdef PARTIAL_XFER_COUNT_EN
        chk("cnt reset", 32'(xfer_count), 32'd0);
        stream(5);
        chk("cnt five", 32'(xfer_count), 32'd5);
        do_reset();
        chk("cnt cleared", 32'(xfer_count), 32'd0);
        stream(65534);
        chk("cnt fffe", 32'(xfer_count), 32'hFFFE);
        stream(3);
        chk("cnt saturate", 32'(xfer_count), 32'hFFFF);
        drive(1'b1, 4'b0001, 2'b11, 2'b00, 1'b1);
        repeat (4) tick();
        chk("cnt held at max", 32'(xfer_count), 32'hFFFF);
        #2 ASYNCRESETN = 1'b0;
        #1 chk("cnt async rst", 32'(xfer_count), 32'd0);
        drive(1'b0, 4'b0000, 2'b00, 2'b00, 1'b0);
        tick();
        #2 ASYNCRESETN = 1'b1;
        tick();
        got.delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
